// File: rtl/launch_ctrl_pkg.sv
// Shared game constants: grid limits, missile slot count and FSM encodings.
package launch_ctrl_pkg;
  localparam int X_MAX     = 3;
  localparam int Y_MAX     = 2;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALLOC  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_COOL   = 2'd3
  } state_t;
endpackage

// File: rtl/launch_ctrl_if.sv
// Player/missile side signals of the launch controller.
interface launch_ctrl_if;
  import launch_ctrl_pkg::*;
  logic                 fire_n;
  logic [3:0]           cursor_x;
  logic [3:0]           cursor_y;
  logic [NUM_SLOTS-1:0] slot_done;
  logic                 reload;
  logic                 launch;
  logic [SLOT_W-1:0]    launch_slot;
  logic [3:0]           launch_x;
  logic [3:0]           launch_y;
  logic [3:0]           ammo;
  logic [NUM_SLOTS-1:0] busy;
  logic                 cooling;

  modport master (
    output fire_n, cursor_x, cursor_y, slot_done, reload,
    input  launch, launch_slot, launch_x, launch_y, ammo, busy, cooling
  );
  modport slave (
    input  fire_n, cursor_x, cursor_y, slot_done, reload,
    output launch, launch_slot, launch_x, launch_y, ammo, busy, cooling
  );
endinterface

// File: rtl/launch_ctrl_slot_pick.sv
// Round-robin free-slot picker: first clear bit of busy at ptr, ptr+1, ...
module slot_pick
  import launch_ctrl_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] busy,
  input  logic [SLOT_W-1:0]    ptr,
  output logic                 found,
  output logic [SLOT_W-1:0]    slot
);
  logic [SLOT_W-1:0] idx;

  // Scan farthest offset first so the nearest free slot to ptr is the last write.
  always_comb begin
    found = 1'b0;
    slot  = '0;
    idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = ptr + SLOT_W'(i);
      if (!busy[idx]) begin
        found = 1'b1;
        slot  = idx;
      end
    end
  end
endmodule

// File: rtl/launch_ctrl.sv
// Missile launch controller: debounced-free fire press -> slot allocation ->
// one-cycle launch pulse -> fixed cooldown. Tracks ammo and slot occupancy.
module launch_ctrl
  import launch_ctrl_pkg::*;
#(
  parameter int COOLDOWN  = 25000000,
  parameter int AMMO_INIT = 10
) (
  input logic         clk,
  input logic         rst,
  launch_ctrl_if.slave io
);
  localparam int            CW        = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(COOLDOWN - 1);
  localparam logic [3:0]    AMMO_RST  = 4'(AMMO_INIT);

  state_t               state, state_nxt;
  logic                 sync1, sync2, sync3;
  logic                 press;
  logic                 accept;
  logic                 pick_found;
  logic [SLOT_W-1:0]    pick_slot;
  logic [SLOT_W-1:0]    ptr;
  logic [SLOT_W-1:0]    slot_r;
  logic [3:0]           tgt_x, tgt_y;
  logic [3:0]           lx, ly;
  logic [3:0]           ammo_r;
  logic [NUM_SLOTS-1:0] busy_r;
  logic [NUM_SLOTS-1:0] set_mask;
  logic [CW-1:0]        cnt;
  logic                 launch_c, cooling_c;

  // fire_n is asynchronous: two sync flops plus one history flop for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= io.fire_n;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign press  = sync3 & ~sync2;
  assign accept = press && (ammo_r != 4'd0) && (busy_r != {NUM_SLOTS{1'b1}}) &&
                  (io.cursor_x <= 4'(X_MAX)) && (io.cursor_y <= 4'(Y_MAX));

  slot_pick u_pick (
    .busy  (busy_r),
    .ptr   (ptr),
    .found (pick_found),
    .slot  (pick_slot)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and decoded outputs; presses outside IDLE are simply not looked at
  always_comb begin
    state_nxt = state;
    launch_c  = 1'b0;
    cooling_c = 1'b0;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ALLOC;
      ST_ALLOC:  state_nxt = pick_found ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: begin
        launch_c  = 1'b1;
        state_nxt = ST_COOL;
      end
      ST_COOL: begin
        cooling_c = 1'b1;
        if (cnt == '0) state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Target capture: cursor on accept, published slot/coords only when a slot is won
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_x  <= '0;
      tgt_y  <= '0;
      slot_r <= '0;
      lx     <= '0;
      ly     <= '0;
    end else begin
      if (state == ST_IDLE && accept) begin
        tgt_x <= io.cursor_x;
        tgt_y <= io.cursor_y;
      end
      if (state == ST_ALLOC && pick_found) begin
        slot_r <= pick_slot;
        lx     <= tgt_x;
        ly     <= tgt_y;
      end
    end
  end

  assign set_mask = launch_c ? (NUM_SLOTS'(1) << slot_r) : '0;

  // Occupancy: slot_done clears in any state; the launch set takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_r <= '0;
    else      busy_r <= (busy_r & ~io.slot_done) | set_mask;
  end

  // Ammo: reload beats the launch decrement; never goes below zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            ammo_r <= AMMO_RST;
    else if (io.reload)                  ammo_r <= AMMO_RST;
    else if (launch_c && ammo_r != 4'd0) ammo_r <= ammo_r - 4'd1;
  end

  // Round-robin pointer and cooldown counter, both armed on LAUNCH exit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (launch_c) begin
      ptr <= slot_r + SLOT_W'(1);
      cnt <= CNT_LOAD;
    end else if (state == ST_COOL && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign io.launch      = launch_c;
  assign io.cooling     = cooling_c;
  assign io.launch_slot = slot_r;
  assign io.launch_x    = lx;
  assign io.launch_y    = ly;
  assign io.ammo        = ammo_r;
  assign io.busy        = busy_r;
endmodule
